// File: rtl/abcd_seq_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// abcd_pkg
// Shared types and defaults for the a/b/c/d sequencing arbiter.
//   state_t          : transaction FSM states
//   *_DEFAULT        : default parameter values for the top level
//   onehot_to_idx()  : index of the set bit in a one-hot vector (up to 16 bits)
// -----------------------------------------------------------------------------
package abcd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_A = 3'd1,
        ISSUE_B = 3'd2,
        WAIT_C  = 3'd3,
        WAIT_D  = 3'd4
    } state_t;

    localparam int N_REQ_DEFAULT   = 4;
    localparam int TIMEOUT_DEFAULT = 8;
    localparam int CW_DEFAULT      = 8;

    // Returns the index of the (single) set bit; 0 when the vector is empty.
    function automatic int onehot_to_idx(input logic [15:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/abcd_seq_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin selector. The search starts at the index after the last winner;
// the last-winner register resets to N-1 so requester 0 has top priority.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector
//   pointer    : index of the winner to remember when load is high
//   load       : commit pointer as the new last winner
//   winner     : combinational one-hot winner (zero when req is zero)
// -----------------------------------------------------------------------------
module rr_arbiter
    import abcd_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [N-1:0]                          req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0]  pointer,
    input  logic                                  load,
    output logic [N-1:0]                          winner
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_last;
    logic [N-1:0]  w_winner;
    logic          w_found;
    int            w_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= PW'(N - 1);
        end else if (load) begin
            r_last <= pointer;
        end
    end

    // Scan N positions starting just after r_last, wrapping once.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(r_last) + 1 + k;
            if (w_idx >= N) w_idx = w_idx - N;
            if (!w_found && req[w_idx[PW-1:0]]) begin
                w_winner[w_idx[PW-1:0]] = 1'b1;
                w_found                 = 1'b1;
            end
        end
    end

    assign winner = w_winner;

endmodule

// File: rtl/abcd_seq_arbiter.sv
// -----------------------------------------------------------------------------
// abcd_seq_arbiter
// Shares one a/b/c/d handshake target among N_REQ requesters. Each
// transaction grants one requester round-robin, issues a then b on
// consecutive cycles, requires c on the cycle after b, then waits for d
// (bounded by TIMEOUT cycles) and pulses done or err to the granted requester.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req          : per-requester level request
//   gnt          : one-hot grant, held for the whole transaction
//   done / err   : one-cycle completion / failure pulse to the granted requester
//   err_timeout  : with err: 1 = d timeout, 0 = missing c
//   a_o, b_o     : issue phases to the target
//   c_i, d_i     : target acknowledge and completion
//   busy         : high whenever the FSM is not IDLE
// Handshake: a_o is high for one cycle, b_o the next; c_i must be high in the
// cycle after b_o (sampled at the end of WAIT_C); d_i is sampled only in
// WAIT_D. All outputs are registered.
// -----------------------------------------------------------------------------
module abcd_seq_arbiter
    import abcd_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CW      = CW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] err,
    output logic             err_timeout,
    output logic             a_o,
    output logic             b_o,
    input  logic             c_i,
    input  logic             d_i,
    output logic             busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_done;
    logic [N_REQ-1:0] r_err;
    logic             r_err_timeout;
    logic             r_a;
    logic             r_b;
    logic             r_busy;

    logic [N_REQ-1:0] w_winner;
    logic [15:0]      w_winner_ext;
    logic [PW-1:0]    w_win_idx;
    logic             w_load;

    assign w_winner_ext = 16'(w_winner);
    assign w_win_idx    = PW'(onehot_to_idx(w_winner_ext));
    // The pointer moves only on the edge that starts a transaction.
    assign w_load       = (r_state == IDLE) && (|req);

    rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .pointer (w_win_idx),
        .load    (w_load),
        .winner  (w_winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_gnt         <= '0;
            r_done        <= '0;
            r_err         <= '0;
            r_err_timeout <= 1'b0;
            r_a           <= 1'b0;
            r_b           <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-armed below.
            r_done        <= '0;
            r_err         <= '0;
            r_err_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_gnt   <= w_winner;
                        r_a     <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ISSUE_A;
                    end
                end
                ISSUE_A: begin
                    r_a     <= 1'b0;
                    r_b     <= 1'b1;
                    r_state <= ISSUE_B;
                end
                ISSUE_B: begin
                    r_b     <= 1'b0;
                    r_state <= WAIT_C;
                end
                WAIT_C: begin
                    if (c_i) begin
                        r_cnt   <= '0;
                        r_state <= WAIT_D;
                    end else begin
                        r_err   <= r_gnt;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                WAIT_D: begin
                    // d_i has priority over a timeout on the same cycle.
                    if (d_i) begin
                        r_done  <= r_gnt;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_err         <= r_gnt;
                        r_err_timeout <= 1'b1;
                        r_gnt         <= '0;
                        r_busy        <= 1'b0;
                        r_state       <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_a     <= 1'b0;
                    r_b     <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign done        = r_done;
    assign err         = r_err;
    assign err_timeout = r_err_timeout;
    assign a_o         = r_a;
    assign b_o         = r_b;
    assign busy        = r_busy;

endmodule

// File: tb/tb_abcd_seq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_abcd_seq_arbiter
// Directed bench for abcd_seq_arbiter (N_REQ=4, TIMEOUT=8). Inputs are driven
// 1 ns after a rising edge and outputs are read at the same point, so after
// tick() the outputs show what the previous edge registered.
// -----------------------------------------------------------------------------
module tb_abcd_seq_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] done;
    logic [3:0] err;
    logic       err_timeout;
    logic       a_o;
    logic       b_o;
    logic       c_i;
    logic       d_i;
    logic       busy;

    int n_checks;
    int n_errors;

    abcd_seq_arbiter #(.N_REQ(4), .TIMEOUT(8), .CW(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .gnt         (gnt),
        .done        (done),
        .err         (err),
        .err_timeout (err_timeout),
        .a_o         (a_o),
        .b_o         (b_o),
        .c_i         (c_i),
        .d_i         (d_i),
        .busy        (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Structural invariants, checked every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("inv_gnt_onehot0", 4'($onehot0(gnt)), 4'd1);
            check("inv_done_err_excl", 4'((|done) && (|err)), 4'd0);
            check("inv_a_b_excl", 4'(a_o && b_o), 4'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant plus a/b issue; returns in the WAIT_C cycle.
    task automatic start_txn(input string tag, input logic [3:0] r, input logic [3:0] eg,
                             input bit hold);
        req = r;
        tick();
        check({tag, "_gnt0"}, gnt, eg);
        check({tag, "_a0"}, 4'(a_o), 4'd1);
        check({tag, "_b0"}, 4'(b_o), 4'd0);
        check({tag, "_busy0"}, 4'(busy), 4'd1);
        if (!hold) req = '0;
        tick();
        check({tag, "_gnt1"}, gnt, eg);
        check({tag, "_a1"}, 4'(a_o), 4'd0);
        check({tag, "_b1"}, 4'(b_o), 4'd1);
        tick();
        check({tag, "_gnt2"}, gnt, eg);
        check({tag, "_b2"}, 4'(b_o), 4'd0);
        check({tag, "_busy2"}, 4'(busy), 4'd1);
    endtask

    // From WAIT_C: ack c, keep d low for d_wait WAIT_D cycles, then raise d.
    task automatic finish_ok(input string tag, input logic [3:0] eg, input int d_wait);
        c_i = 1'b1;
        tick();
        c_i = 1'b0;
        check({tag, "_waitd_busy"}, 4'(busy), 4'd1);
        check({tag, "_waitd_done"}, done, 4'd0);
        for (int i = 0; i < d_wait; i++) begin
            tick();
            check({tag, "_hold_done"}, done, 4'd0);
            check({tag, "_hold_err"}, err, 4'd0);
            check({tag, "_hold_gnt"}, gnt, eg);
        end
        d_i = 1'b1;
        tick();
        d_i = 1'b0;
        check({tag, "_done"}, done, eg);
        check({tag, "_done_err"}, err, 4'd0);
        check({tag, "_done_gnt"}, gnt, 4'd0);
        check({tag, "_done_busy"}, 4'(busy), 4'd0);
        check({tag, "_done_a"}, 4'(a_o), 4'd0);
    endtask

    // From WAIT_C: ack c, never raise d; err must arrive after 8 WAIT_D cycles.
    task automatic finish_timeout(input string tag, input logic [3:0] eg);
        c_i = 1'b1;
        tick();
        c_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check({tag, "_pre_err"}, err, 4'd0);
            check({tag, "_pre_gnt"}, gnt, eg);
        end
        tick();
        check({tag, "_err"}, err, eg);
        check({tag, "_err_to"}, 4'(err_timeout), 4'd1);
        check({tag, "_err_done"}, done, 4'd0);
        check({tag, "_err_gnt"}, gnt, 4'd0);
        check({tag, "_err_busy"}, 4'(busy), 4'd0);
        tick();
        check({tag, "_err_clr"}, err, 4'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] rr_exp [5];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        req      = '0;
        c_i      = 1'b0;
        d_i      = 1'b0;
        rr_exp   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        repeat (2) tick();
        check("rst_gnt", gnt, 4'd0);
        check("rst_done", done, 4'd0);
        check("rst_err", err, 4'd0);
        check("rst_err_to", 4'(err_timeout), 4'd0);
        check("rst_a", 4'(a_o), 4'd0);
        check("rst_b", 4'(b_o), 4'd0);
        check("rst_busy", 4'(busy), 4'd0);
        rst_n = 1'b1;
        tick();
        check("idle_no_req_busy", 4'(busy), 4'd0);

        // Round-robin with all requests held: 0001,0010,0100,1000,0001.
        for (int i = 0; i < 5; i++) begin
            start_txn("rr", 4'b1111, rr_exp[i], 1'b1);
            finish_ok("rr", rr_exp[i], 0);
        end
        req = '0;
        tick();
        check("rr_idle_a", 4'(a_o), 4'd0);

        // Normal transaction: d in the third WAIT_D cycle.
        start_txn("t1", 4'b0010, 4'b0010, 1'b0);
        finish_ok("t1", 4'b0010, 2);
        tick();
        check("t1_done_clr", done, 4'd0);

        // Missing c (d high in WAIT_C must be ignored).
        start_txn("t2", 4'b0001, 4'b0001, 1'b0);
        c_i = 1'b0;
        d_i = 1'b1;
        tick();
        d_i = 1'b0;
        check("t2_err", err, 4'b0001);
        check("t2_err_to", 4'(err_timeout), 4'd0);
        check("t2_done", done, 4'd0);
        check("t2_gnt", gnt, 4'd0);
        check("t2_busy", 4'(busy), 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_no_reissue_a", 4'(a_o), 4'd0);
            check("t2_err_clr", err, 4'd0);
        end

        // d timeout.
        start_txn("t3", 4'b0100, 4'b0100, 1'b0);
        finish_timeout("t3", 4'b0100);

        // d arrives on the last allowed WAIT_D cycle: done wins over timeout.
        start_txn("t4", 4'b1000, 4'b1000, 1'b0);
        finish_ok("t4", 4'b1000, 7);
        tick();
        check("t4_no_err", err, 4'd0);

        // Asynchronous reset in WAIT_D, then pointer must be back at 0.
        start_txn("t5", 4'b0010, 4'b0010, 1'b0);
        c_i = 1'b1;
        tick();
        c_i = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_gnt", gnt, 4'd0);
        check("t5_async_busy", 4'(busy), 4'd0);
        check("t5_async_done", done, 4'd0);
        check("t5_async_err", err, 4'd0);
        d_i = 1'b1;
        tick();
        d_i = 1'b0;
        check("t5_rst_done", done, 4'd0);
        check("t5_rst_err", err, 4'd0);
        check("t5_rst_a", 4'(a_o), 4'd0);
        rst_n = 1'b1;
        start_txn("t5b", 4'b1001, 4'b0001, 1'b0);
        finish_ok("t5b", 4'b0001, 0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
